serial_word_deframer: RTL and testbench

SERIAL_WORD_DEFRAMER -- requirements
Module: serial_word_deframer

---
 rtl/dnnbp_pkg.sv | 16 +
 rtl/deframe_shift_reg.sv | 26 ++
 rtl/serial_word_deframer.sv | 154 +++++++++++++++
 tb/tb_serial_word_deframer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dnnbp_pkg.sv
// Shared definitions for the serial deframing stages: FSM state encoding and
// the width helper for bit counters.
package dnnbp_pkg;

  // Deframer control states: waiting for a start-of-frame, or acquiring bits.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACQ  = 1'b1
  } dfr_state_e;

  // Width of a counter that must hold every value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/deframe_shift_reg.sv
// N-bit right-shifting register: each enabled bit enters at the MSB, so after
// N shifts the first bit received sits in bit 0.
module deframe_shift_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] shift_q;

  // Shift right by one place on every enabled edge; cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (en_i) begin
      shift_q <= {bit_i, shift_q[N-1:1]};
    end
  end

  assign q_o = shift_q;

endmodule

// File: rtl/serial_word_deframer.sv
// Serial-to-parallel deframer: collects N LSB-first bits after a start-of-frame
// marker, presents the word on a valid/ready output slot, and reports dropped
// words (overrun) and premature start-of-frame markers (frame_err).
module serial_word_deframer
  import dnnbp_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_in,
  input  logic         s_valid,
  input  logic         s_sof,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         overrun,
  output logic         frame_err,
  input  logic         clr_err
);

  localparam int             CW       = cnt_width(N);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(N);

  dfr_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  logic [N-1:0]  shift_word;
  logic [N-1:0]  m_data_q;
  logic          m_valid_q;
  logic          overrun_q;
  logic          frame_err_q;

  logic          word_done;
  logic          shift_en;
  logic          slot_free;
  logic          load_word;
  logic          overrun_set;
  logic          frame_err_set;

  // A word is complete on the edge after its Nth bit was sampled.
  assign word_done = (state_q == ST_ACQ) && (count_q == CNT_FULL);

  deframe_shift_reg #(.N(N)) u_shift (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (shift_en),
    .bit_i (s_in),
    .q_o   (shift_word)
  );

  // State and bit-count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic. On the completion edge the input is treated exactly as in
  // IDLE, so a start-of-frame arriving right behind a finished word is kept.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_valid && s_sof) begin
          state_d = ST_ACQ;
          count_d = CNT_ONE;
        end
      end
      ST_ACQ: begin
        if (word_done) begin
          if (s_valid && s_sof) begin
            state_d = ST_ACQ;
            count_d = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            count_d = '0;
          end
        end else if (s_valid) begin
          if (s_sof) begin
            count_d = CNT_ONE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Per-edge control decodes: shift enable, word load/drop and flag set events.
  always_comb begin
    shift_en      = 1'b0;
    frame_err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: shift_en = s_valid && s_sof;
      ST_ACQ: begin
        shift_en      = s_valid && (!word_done || s_sof);
        frame_err_set = s_valid && s_sof && !word_done;
      end
      default: shift_en = 1'b0;
    endcase
    slot_free   = !m_valid_q || m_ready;
    load_word   = word_done && slot_free;
    overrun_set = word_done && !slot_free;
  end

  // Output slot: load a completed word when free, otherwise drain on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else if (load_word) begin
      m_data_q  <= shift_word;
      m_valid_q <= 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Sticky error flags; a set event on the same edge beats clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (clr_err) begin
        overrun_q <= 1'b0;
      end
      if (frame_err_set) begin
        frame_err_q <= 1'b1;
      end else if (clr_err) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_word_deframer.sv
// Directed bench for serial_word_deframer (N=8) with a word scoreboard:
// stimulus pushes expected words, a monitor pops them on each handshake.
module tb_serial_word_deframer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         s_in = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_sof = 1'b0;
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         overrun;
  logic         frame_err;
  logic         clr_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_q[$];

  serial_word_deframer #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .s_sof     (s_sof),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 5000 cycles");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && m_valid && m_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected: got m_data=0x%02h, expected no word", m_data);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_fail++;
          $display("FAIL word_data: got m_data=0x%02h, expected 0x%02h", m_data, e);
        end else begin
          $display("word accepted: m_data=0x%02h", m_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("check %s: 0x%0h ok", name, act);
    end
  endtask

  task automatic send_bit(input logic b, input logic sof);
    @(posedge clk);
    #2;
    s_valid = 1'b1;
    s_in    = b;
    s_sof   = sof;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_in    = 1'b0;
    end
  endtask

  task automatic send_word(input logic [N-1:0] w);
    for (int i = 0; i < N; i++) send_bit(w[i], i == 0);
  endtask

  initial begin
    logic [N-1:0] w;

    // Reset state
    #3;
    check("reset_m_data", 32'(m_data), 0);
    check("reset_m_valid", 32'(m_valid), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    @(posedge clk); #2; reset = 1'b1;

    // 0xA5 with m_ready=1: exact one-clock latency and one-cycle valid
    m_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_word(8'hA5);
    idle(1);
    @(negedge clk);
    check("a5_valid_before", 32'(m_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("a5_valid_latency", 32'(m_valid), 1);
    check("a5_data", 32'(m_data), 32'hA5);
    @(posedge clk);
    @(negedge clk);
    check("a5_valid_drained", 32'(m_valid), 0);

    // Same frame with a 3-clock gap after bit 4
    exp_q.push_back(8'hA5);
    w = 8'hA5;
    for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
    idle(3);
    for (int i = 4; i < N; i++) send_bit(w[i], 1'b0);
    idle(4);
    @(negedge clk);
    check("gap_overrun", 32'(overrun), 0);
    check("gap_frame_err", 32'(frame_err), 0);

    // Back-to-back 0x3C, 0xC3 with m_ready=0: second word dropped
    @(posedge clk); #2; m_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_word(8'h3C);
    send_word(8'hC3);
    idle(4);
    @(negedge clk);
    check("ovr_valid_held", 32'(m_valid), 1);
    check("ovr_data_held", 32'(m_data), 32'h3C);
    check("ovr_flag", 32'(overrun), 1);
    @(posedge clk); #2; m_ready = 1'b1;
    @(posedge clk); #2; m_ready = 1'b0;
    @(negedge clk);
    check("ovr_drained", 32'(m_valid), 0);
    @(posedge clk); #2; clr_err = 1'b1;
    @(posedge clk); #2; clr_err = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 0);

    // Simultaneous drain and load: 0x5A held, 0x69 completes as 0x5A leaves
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h69);
    send_word(8'h5A);
    idle(3);
    send_word(8'h69);
    idle(1);
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("dl_valid_kept", 32'(m_valid), 1);
    check("dl_new_word", 32'(m_data), 32'h69);
    idle(2);
    @(negedge clk);
    check("dl_no_overrun", 32'(overrun), 0);

    // Start-of-frame at bit 5 restarts acquisition with 0x0F
    exp_q.push_back(8'h0F);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_word(8'h0F);
    idle(4);
    @(negedge clk);
    check("ferr_flag", 32'(frame_err), 1);
    check("ferr_no_overrun", 32'(overrun), 0);
    @(posedge clk); #2; clr_err = 1'b1;
    @(posedge clk); #2; clr_err = 1'b0;
    @(negedge clk);
    check("ferr_cleared", 32'(frame_err), 0);

    // Reset mid-frame after 4 bits, then a clean 0x81
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    @(posedge clk); #2;
    s_valid = 1'b0; s_sof = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    @(negedge clk);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    @(posedge clk); #2; reset = 1'b1;
    exp_q.push_back(8'h81);
    send_word(8'h81);
    idle(4);
    @(negedge clk);
    check("post_rst_flags", 32'({overrun, frame_err}), 0);

    // 0xFF stream without start-of-frame is ignored
    for (int i = 0; i < N; i++) begin
      send_bit(1'b1, 1'b0);
      @(negedge clk);
      check("nosof_valid", 32'(m_valid), 0);
    end
    idle(4);
    @(negedge clk);
    check("nosof_valid_end", 32'(m_valid), 0);
    check("nosof_flags", 32'({overrun, frame_err}), 0);

    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
